// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: registered request/response front end for the combinational alu.
// Optional feature macro: ALU_SEQ_MUL_EN adds an n-cycle shift-and-add multiply
// (op 4'b1111) built by iterating the ALU's RCA operation.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; alu_* hold their last value
// EXEC   | alu_* driven from the registered request; capture result
// MUL    | one shift-and-add iteration per cycle (ALU_SEQ_MUL_EN only)
// RESP   | response presented until rsp_ready; everything held stable
module alu_seq_ctrl #(
    parameter int n = 32,
    parameter int m = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [n-1:0] req_a,
    input  logic [n-1:0] req_b,
    input  logic [m-1:0] req_op,
    input  logic         req_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_res,
    output logic         rsp_cout,
    output logic         rsp_flag_neg,
    output logic         rsp_flag_overflow,
    output logic         rsp_flag_null,
    output logic         rsp_err,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [m-1:0] alu_sel,
    output logic         alu_cin,
    input  logic [n-1:0] alu_res,
    input  logic         alu_cout,
    input  logic         alu_flag_neg,
    input  logic         alu_flag_overflow,
    input  logic         alu_flag_null
);

    localparam logic [m-1:0] OP_RCA      = m'(0);
    localparam logic [m-1:0] OP_RCS      = m'(1);
    localparam logic [m-1:0] OP_AND      = m'(2);
    localparam logic [m-1:0] OP_OR       = m'(3);
    localparam logic [m-1:0] OP_XOR      = m'(4);
    localparam logic [m-1:0] OP_SHIFT_LS = m'(5);
    localparam logic [m-1:0] OP_SHIFT_LD = m'(6);
    localparam logic [m-1:0] OP_SHIFT_AS = m'(7);
    localparam logic [m-1:0] OP_SHIFT_AD = m'(8);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [m-1:0] OP_MUL      = m'(15);
    localparam int           CNT_W       = (n > 1) ? $clog2(n) : 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
`ifdef ALU_SEQ_MUL_EN
        S_MUL  = 2'd2,
`endif
        S_RESP = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic         req_ready_q, req_ready_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [n-1:0] rsp_res_q, rsp_res_d;
    logic         rsp_cout_q, rsp_cout_d;
    logic         rsp_neg_q, rsp_neg_d;
    logic         rsp_ovf_q, rsp_ovf_d;
    logic         rsp_null_q, rsp_null_d;
    logic         rsp_err_q, rsp_err_d;
    logic [n-1:0] alu_a_q, alu_a_d;
    logic [n-1:0] alu_b_q, alu_b_d;
    logic [m-1:0] alu_sel_q, alu_sel_d;
    logic         alu_cin_q, alu_cin_d;
    logic         op_supported;
`ifdef ALU_SEQ_MUL_EN
    logic [n-1:0]     acc_q, acc_d;
    logic [n-1:0]     mcand_q, mcand_d;
    logic [n-1:0]     mplier_q, mplier_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // alu_sel_q holds the requested op while in EXEC
    assign op_supported = alu_sel_q inside {OP_RCA, OP_RCS, OP_AND, OP_OR, OP_XOR,
                                            OP_SHIFT_LS, OP_SHIFT_LD, OP_SHIFT_AS, OP_SHIFT_AD};

    // State and datapath registers, synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_null_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_cin_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_neg_q   <= rsp_neg_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_null_q  <= rsp_null_d;
            rsp_err_q   <= rsp_err_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            alu_cin_q   <= alu_cin_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Next-state and next-datapath logic; everything holds unless a state changes it
    always_comb begin
        state_d    = state_q;
        rsp_res_d  = rsp_res_q;
        rsp_cout_d = rsp_cout_q;
        rsp_neg_d  = rsp_neg_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_null_d = rsp_null_q;
        rsp_err_d  = rsp_err_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        alu_cin_d  = alu_cin_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    // Operands go straight into the alu_* registers so the ALU
                    // settles during the EXEC cycle.
                    alu_a_d   = req_a;
                    alu_b_d   = req_b;
                    alu_sel_d = req_op;
                    alu_cin_d = req_cin;
                    state_d   = S_EXEC;
`ifdef ALU_SEQ_MUL_EN
                    if (req_op == OP_MUL) begin
                        acc_d     = '0;
                        mcand_d   = req_a;
                        mplier_d  = req_b;
                        ovf_d     = 1'b0;
                        cnt_d     = CNT_W'(n - 1);
                        alu_a_d   = '0;
                        alu_b_d   = req_a;
                        alu_sel_d = OP_RCA;
                        alu_cin_d = 1'b0;
                        state_d   = S_MUL;
                    end
`endif
                end
            end
            S_EXEC: begin
                if (op_supported) begin
                    rsp_res_d  = alu_res;
                    rsp_cout_d = alu_cout;
                    rsp_neg_d  = alu_flag_neg;
                    rsp_ovf_d  = alu_flag_overflow;
                    rsp_null_d = alu_flag_null;
                    rsp_err_d  = 1'b0;
                end else begin
                    rsp_res_d  = '0;
                    rsp_cout_d = 1'b0;
                    rsp_neg_d  = 1'b0;
                    rsp_ovf_d  = 1'b0;
                    rsp_null_d = 1'b0;
                    rsp_err_d  = 1'b1;
                end
                state_d = S_RESP;
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = alu_res;
                end
                // Overflow: a carry out of the accumulator, or a multiplicand
                // bit shifted out while higher multiplier bits are still set.
                ovf_d = ovf_q | (mplier_q[0] & alu_cout)
                              | (mcand_q[n-1] & (mplier_q[n-1:1] != '0));
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) begin
                    rsp_res_d  = acc_d;
                    rsp_cout_d = ovf_d;
                    rsp_neg_d  = acc_d[n-1];
                    rsp_ovf_d  = 1'b0;
                    rsp_null_d = (acc_d == '0);
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    alu_a_d = acc_d;
                    alu_b_d = mcand_d;
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    assign req_ready         = req_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_res           = rsp_res_q;
    assign rsp_cout          = rsp_cout_q;
    assign rsp_flag_neg      = rsp_neg_q;
    assign rsp_flag_overflow = rsp_ovf_q;
    assign rsp_flag_null     = rsp_null_q;
    assign rsp_err           = rsp_err_q;
    assign alu_a             = alu_a_q;
    assign alu_b             = alu_b_q;
    assign alu_sel           = alu_sel_q;
    assign alu_cin           = alu_cin_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: drives alu_seq_ctrl with a behavioural ALU attached and
// checks every response against a reference computed from the request alone.
// Follows ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq_ctrl;

    localparam int N = 32;
    localparam int M = 4;

    typedef struct packed {
        logic [N-1:0] res;
        logic         cout;
        logic         neg;
        logic         ovf;
        logic         nul;
        logic         err;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_a, req_b;
    logic [M-1:0] req_op;
    logic         req_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_res;
    logic         rsp_cout, rsp_flag_neg, rsp_flag_overflow, rsp_flag_null, rsp_err;
    logic [N-1:0] alu_a, alu_b;
    logic [M-1:0] alu_sel;
    logic         alu_cin;
    logic [N-1:0] alu_res;
    logic         alu_cout, alu_flag_neg, alu_flag_overflow, alu_flag_null;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.n(N), .m(M)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_cout(rsp_cout), .rsp_flag_neg(rsp_flag_neg),
        .rsp_flag_overflow(rsp_flag_overflow), .rsp_flag_null(rsp_flag_null),
        .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_cout(alu_cout), .alu_flag_neg(alu_flag_neg),
        .alu_flag_overflow(alu_flag_overflow), .alu_flag_null(alu_flag_null)
    );

    // Behavioural ALU: 0 RCA, 1 RCS, 2 AND, 3 OR, 4 XOR, 5-8 shifts by b[4:0].
    // Undefined selects return junk so a missing error path shows up.
    function automatic rsp_t alu_fn(input logic [N-1:0] a, b, input logic [M-1:0] sel,
                                    input logic cin);
        rsp_t r;
        logic [N:0] s;
        r = '0;
        case (sel)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
                r.res = s[N-1:0];
                r.cout = s[N];
                r.ovf = (a[N-1] == b[N-1]) && (r.res[N-1] != a[N-1]);
            end
            4'd1: begin
                r.res = a - b;
                r.cout = (a >= b);
                r.ovf = (a[N-1] != b[N-1]) && (r.res[N-1] != a[N-1]);
            end
            4'd2: r.res = a & b;
            4'd3: r.res = a | b;
            4'd4: r.res = a ^ b;
            4'd5: r.res = a << b[4:0];
            4'd6: r.res = a >> b[4:0];
            4'd7: r.res = a <<< b[4:0];
            4'd8: r.res = N'($signed(a) >>> b[4:0]);
            default: begin
                r.res = ~a;
                r.cout = 1'b1;
                r.ovf = 1'b1;
            end
        endcase
        r.neg = r.res[N-1];
        r.nul = (r.res == '0);
        if (sel > 4'd8) begin
            r.neg = 1'b1;
            r.nul = 1'b1;
        end
        return r;
    endfunction

    // Expected response from the request alone
    function automatic rsp_t ref_model(input logic [N-1:0] a, b, input logic [M-1:0] op,
                                       input logic cin);
        rsp_t r;
        logic [2*N-1:0] prod;
        r = '0;
        if (op <= 4'd8) begin
            r = alu_fn(a, b, op, cin);
`ifdef ALU_SEQ_MUL_EN
        end else if (op == 4'd15) begin
            prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
            r.res = prod[N-1:0];
            r.cout = (prod[2*N-1:N] != '0);
            r.neg = prod[N-1];
            r.nul = (prod[N-1:0] == '0);
`endif
        end else begin
            prod = '0;
            r.err = 1'b1;
        end
        return r;
    endfunction

    rsp_t alu_out;
    // Combinational ALU attached to the DUT's alu_* port
    always_comb begin
        alu_out = alu_fn(alu_a, alu_b, alu_sel, alu_cin);
    end
    assign alu_res           = alu_out.res;
    assign alu_cout          = alu_out.cout;
    assign alu_flag_neg      = alu_out.neg;
    assign alu_flag_overflow = alu_out.ovf;
    assign alu_flag_null     = alu_out.nul;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input rsp_t e);
        chk({tag, ".valid"}, 128'(rsp_valid), 128'(1));
        chk({tag, ".rsp"},
            128'({rsp_res, rsp_cout, rsp_flag_neg, rsp_flag_overflow, rsp_flag_null, rsp_err}),
            128'(e));
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({req_ready, rsp_valid, rsp_res, rsp_cout, rsp_flag_neg,
                     rsp_flag_overflow, rsp_flag_null, rsp_err,
                     alu_a, alu_b, alu_sel, alu_cin});
    endfunction

    // One full transaction with cycle-exact latency and backpressure checks
    task automatic do_op(input string tag, input logic [N-1:0] a, b,
                         input logic [M-1:0] op, input logic cin, input int hold);
        rsp_t e;
        int   lat;
        int   g;
        e = ref_model(a, b, op, cin);
        lat = 1;
`ifdef ALU_SEQ_MUL_EN
        if (op == 4'd15) lat = N;
`endif
        @(negedge clk);
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_op = op;
        req_cin = cin;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk({tag, ".accept"}, 128'(req_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a = $urandom;
        req_b = $urandom;
        req_op = 4'($urandom);
        req_cin = 1'($urandom);
        chk({tag, ".busy"}, 128'(req_ready), 128'(0));
        if (lat == 1)
            chk({tag, ".alu_in"}, 128'({alu_a, alu_b, alu_sel, alu_cin}),
                128'({a, b, op, cin}));
        for (int k = 0; k < lat; k++) begin
            chk({tag, ".early"}, 128'(rsp_valid), 128'(0));
            @(negedge clk);
        end
        chk_rsp(tag, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk_rsp({tag, ".hold"}, e);
            chk({tag, ".hold_rdy"}, 128'(req_ready), 128'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".done"}, 128'({rsp_valid, req_ready}), 128'(2'b01));
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic [M-1:0] rop;
        rst = 1'b1;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        req_cin = 1'b0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 128'({req_ready, rsp_valid}), 128'(2'b10));

        do_op("rca_1_1", 32'd1, 32'd1, 4'd0, 1'b0, 0);
        do_op("rcs_2_1", 32'd2, 32'd1, 4'd1, 1'b0, 3);
        do_op("rca_cin_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'd0, 1'b1, 1);
        do_op("rca_carry_null", 32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 1'b0, 0);
        do_op("shift_ad", 32'h8000_0010, 32'd4, 4'd8, 1'b0, 0);
        do_op("op_9_err", 32'h1234_5678, 32'h9, 4'd9, 1'b1, 0);
        do_op("op_15", 32'd7, 32'd6, 4'd15, 1'b0, 0);
`ifdef ALU_SEQ_MUL_EN
        do_op("mul_ff_2", 32'hFFFF_FFFF, 32'd2, 4'd15, 1'b0, 0);
        do_op("mul_0_5", 32'd0, 32'd5, 4'd15, 1'b0, 2);
        do_op("mul_hi_edge", 32'h8000_0000, 32'd1, 4'd15, 1'b0, 0);
        do_op("mul_hi_ovf", 32'h8000_0000, 32'd2, 4'd15, 1'b0, 0);
`endif

        for (int i = 0; i < 25; i++) begin
            ra = ($urandom_range(0, 1) != 0) ? N'($urandom) : N'($urandom_range(0, 100));
            rb = ($urandom_range(0, 1) != 0) ? N'($urandom) : N'($urandom_range(0, 100));
            rop = M'($urandom_range(0, 15));
            do_op("random", ra, rb, rop, 1'($urandom), $urandom_range(0, 2));
        end

        // Reset while an operation is in flight: no response may come out
        @(negedge clk);
        req_valid = 1'b1;
        req_a = 32'd9;
        req_b = 32'd11;
`ifdef ALU_SEQ_MUL_EN
        req_op = 4'd15;
`else
        req_op = 4'd0;
`endif
        req_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midop_reset_outs", all_outs(), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("midop_ready", 128'({req_ready, rsp_valid}), 128'(2'b10));
        repeat (3) @(negedge clk);
        chk("midop_no_rsp", 128'(rsp_valid), 128'(0));
        do_op("after_reset_3_4", 32'd3, 32'd4, 4'd0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequential front end for the combinational `alu`. Accepts one operation at a time over a valid/ready request channel, drives the ALU's `a`/`b`/`sel`/`cin` from registers, captures `res`/`cout`/flags, and returns them on a valid/ready response channel. With the multiply option compiled in, it also runs an n-cycle shift-and-add multiply by iterating the ALU's `RCA` operation. It sits between an issuing control unit and the `alu` instance, as the registered counterpart to the ALU's stimulus side.

## Interface
- `n`, 32, operand/result width (must match the `alu` instance)
- `m`, 4, op select width (must match the `alu` instance)
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_a`, `req_b`  in  n  operands
- `req_op`  in  m  op code (`defines.v` encodings)
- `req_cin`  in  1  carry in
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes the response
- `rsp_res`  out  n  result
- `rsp_cout`, `rsp_flag_neg`, `rsp_flag_overflow`, `rsp_flag_null`, `rsp_err`  out  1 each  captured flags; `rsp_err` = unsupported op
- `alu_a`, `alu_b`  out  n  to ALU
- `alu_sel`  out  m  to ALU
- `alu_cin`  out  1  to ALU
- `alu_res`  in  n  from ALU
- `alu_cout`, `alu_flag_neg`, `alu_flag_overflow`, `alu_flag_null`  in  1 each  from ALU

## Operation
- States: IDLE, EXEC, MUL, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, register operands, op and cin. If op is `MUL` (4'b1111) and the option is enabled, go to MUL; otherwise go to EXEC.
- EXEC: drive `alu_*` from the registered operands. Capture the ALU outputs into `rsp_*`, then go to RESP.
  - Supported ops: `RCA`, `RCS`, `AND`, `OR`, `XOR`, `SHIFT_LS`, `SHIFT_LD`, `SHIFT_AS`, `SHIFT_AD`.
  - Any other op: `rsp_err`=1, `rsp_res`=0, all other flags 0.
- MUL (n iterations, index i = 0..n-1). Internal registers: `acc`=0, `mcand`=a, `mplier`=b, sticky `ovf`=0. Each cycle:
  - drive `alu_a`=`acc`, `alu_b`=`mcand`, `alu_sel`=`RCA`, `alu_cin`=0;
  - if `mplier[0]`: `acc`<=`alu_res`, and `ovf` |= `alu_cout`;
  - if `mcand[n-1]` and `(mplier>>1)`!=0: `ovf`<=1;
  - `mcand`<<=1, `mplier`>>=1.
  - After iteration n-1, go to RESP with `rsp_res`=`acc` (low n bits of a*b, unsigned), `rsp_cout`=`ovf` (1 exactly when the full product exceeds n bits), `rsp_flag_neg`=`acc[n-1]`, `rsp_flag_null`=(`acc`==0), `rsp_flag_overflow`=0, `rsp_err`=0.
- RESP: `rsp_valid`=1 and all `rsp_*` held stable until `rsp_ready`; on handshake go to IDLE.
- `alu_*` outputs hold their last driven value in IDLE and RESP.
- Reset values: state IDLE; every output 0, including `req_ready` and `rsp_valid`. `req_ready` rises on the first cycle after `rst` deasserts.
- Reset mid-operation: the operation is abandoned and no response is produced.

## Timing
- Request accepted at edge T.
- Single op: EXEC during cycle T+1; `rsp_valid` high from T+2.
- MUL: iterations in cycles T+1..T+n; `rsp_valid` high from T+n+1.
- Response handshake at edge R: `req_ready` high from R+1. There is no same-cycle turnaround; at most one operation is in flight.
- `req_ready` is 0 in EXEC, MUL and RESP. The upstream side must hold `req_*` stable while `req_valid` is high and `req_ready` is low.
- Throughput: 3 cycles per single op with `rsp_ready` tied high.

## Configuration
- `ALU_SEQ_MUL_EN` defined: op 4'b1111 runs the MUL sequence.
- `ALU_SEQ_MUL_EN` undefined: op 4'b1111 is unsupported and takes the EXEC path with `rsp_err`=1. The MUL state and its registers are not synthesized.

## Test plan
- a=1, b=1, op=`RCA`, cin=0 -> `rsp_res`=2 at T+2, `rsp_cout`=0, `rsp_flag_null`=0, `rsp_err`=0.
- a=2, b=1, op=`RCS`; hold `rsp_ready`=0 for 3 cycles -> `rsp_res`=1 held stable, `rsp_valid` stays high, `req_ready`=0 until 1 cycle after the handshake.
- MUL a=7, b=6 (n=32) -> `rsp_res`=42 at T+33, `rsp_cout`=0, `rsp_flag_null`=0.
- MUL a=0xFFFFFFFF, b=2 -> `rsp_res`=0xFFFFFFFE, `rsp_cout`=1, `rsp_flag_neg`=1. MUL a=0, b=5 -> `rsp_res`=0, `rsp_flag_null`=1.
- `ALU_SEQ_MUL_EN` undefined, op=4'b1111 -> `rsp_err`=1, `rsp_res`=0 at T+2.
- Assert `rst` 10 cycles into a MUL -> next cycle all outputs 0, no `rsp_valid`. After `rst` deasserts, a new `RCA` 3+4 returns 7.
